bpsk_rx_frame_ctrl: RTL and testbench

//  Receive-side counterpart of the BPSK transmit controller. Takes the hard phase decision from the demodulator
//  and recovers bit timing from phase transitions. Differentially decodes bits (a phase change means 1).

---
 rtl/bpsk_rx_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bpsk_rx_frame_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_rx_frame_ctrl.sv
// BPSK receive framer: recovers bit timing from phase transitions, decodes bits
// differentially, hunts for a sync word and writes one frame of bytes into RAM.
module bpsk_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned FRAME_LENGTH = 150,
  parameter int unsigned REF_CLK_FREQ = 128000000,
  parameter int unsigned BAUDRATE     = 9600,
  parameter logic [15:0] SYNC_WORD    = 16'hEB90
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rx_en,
  input  logic                  phase_in,
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rst,
  output logic                  locked,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int unsigned CPB  = REF_CLK_FREQ / BAUDRATE;
  localparam int unsigned BC_W = $clog2(CPB);
  localparam logic [BC_W-1:0]       BC_MAX    = BC_W'(CPB - 1);
  localparam logic [BC_W-1:0]       BC_HALF   = BC_W'(CPB / 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LENGTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_CAPTURE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  s1_q, s2_q, s3_q;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic                  prev_q, prev_d;
  // Only the 15 oldest sync bits and 7 oldest data bits need storing; the
  // newest bit is appended combinationally before compare/write.
  logic [14:0]           shreg_q, shreg_d;
  logic [6:0]            byte_q, byte_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic                  ram_en_q, ram_en_d;
  logic                  frame_done_q, frame_done_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic        edge_det, strobe, rx_bit;
  logic [15:0] shreg_next;
  logic [7:0]  byte_next;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      bc_q          <= '0;
      prev_q        <= 1'b0;
      shreg_q       <= '0;
      byte_q        <= '0;
      bit_idx_q     <= '0;
      addr_q        <= '0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_en_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= phase_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      bc_q          <= bc_d;
      prev_q        <= prev_d;
      shreg_q       <= shreg_d;
      byte_q        <= byte_d;
      bit_idx_q     <= bit_idx_d;
      addr_q        <= addr_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_en_q      <= ram_en_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    edge_det   = s2_q ^ s3_q;
    strobe     = (state_q != S_IDLE) && (bc_q == BC_HALF);
    rx_bit     = s2_q ^ prev_q;
    shreg_next = {shreg_q, rx_bit};
    byte_next  = {byte_q, rx_bit};

    state_d       = state_q;
    bc_d          = bc_q;
    prev_d        = prev_q;
    shreg_d       = shreg_q;
    byte_d        = byte_q;
    bit_idx_d     = bit_idx_q;
    addr_d        = addr_q;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    ram_en_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (state_q == S_IDLE) begin
      bc_d   = '0;
      prev_d = 1'b0;
    end else begin
      if (edge_det)           bc_d = BC_W'(1);
      else if (bc_q == BC_MAX) bc_d = '0;
      else                     bc_d = bc_q + BC_W'(1);
      if (strobe) prev_d = s2_q;
    end

    case (state_q)
      S_IDLE: begin
        shreg_d   = '0;
        byte_d    = '0;
        addr_d    = '0;
        bit_idx_d = '0;
        state_d   = S_HUNT;
      end
      S_HUNT: begin
        if (strobe) begin
          shreg_d = shreg_next[14:0];
          if (shreg_next == SYNC_WORD) begin
            state_d   = S_CAPTURE;
            bit_idx_d = '0;
            addr_d    = '0;
          end
        end
      end
      S_CAPTURE: begin
        if (strobe) begin
          byte_d    = byte_next[6:0];
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            ram_en_d      = 1'b1;
            ram_addr_d    = addr_q;
            ram_wr_data_d = DATA_WIDTH'(byte_next);
            if (addr_q == LAST_ADDR) state_d = S_DONE;
            else                     addr_d  = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        shreg_d       = '0;
        state_d       = S_HUNT;
      end
      default: state_d = S_IDLE;
    endcase

    if (!rx_en) begin
      state_d       = S_IDLE;
      ram_en_d      = 1'b0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
    end
  end

  assign ram_clk     = clk;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_en_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign ram_rst     = 1'b0;
  assign locked      = (state_q == S_CAPTURE);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bpsk_rx_frame_ctrl.sv
// Bench for bpsk_rx_frame_ctrl: differential BPSK transmitter plus a bit-level
// frame-recovery reference model; RAM writes and frame pulses are compared to it.
module tb_bpsk_rx_frame_ctrl;

  localparam int FL    = 48;
  localparam int CPB   = 16;
  localparam int PRE   = 20;
  localparam logic [15:0] SYNC = 16'hEB90;

  logic        clk = 1'b0;
  logic        nrst, rx_en, phase_in;
  logic        ram_clk, ram_en, ram_we, ram_rst, locked, frame_done;
  logic [7:0]  ram_addr, ram_wr_data;
  logic [15:0] frame_count;

  bpsk_rx_frame_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAME_LENGTH(FL),
    .REF_CLK_FREQ(160), .BAUDRATE(10), .SYNC_WORD(SYNC)
  ) dut (
    .clk(clk), .nrst(nrst), .rx_en(rx_en), .phase_in(phase_in),
    .ram_clk(ram_clk), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rst(ram_rst), .locked(locked),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  bit          tx_bits[$];
  logic [15:0] wr_q[$], exp_wr[$];
  int          fd_pos[$], exp_fd[$];
  int          exp_frames, exp_fc, we_bad;
  bit          exp_lock, locked_seen;
  logic        start_phase;

  always @(negedge clk) begin
    if (ram_en) begin
      wr_q.push_back({ram_addr, ram_wr_data});
      if (ram_we !== 1'b1) we_bad++;
    end else if (ram_we !== 1'b0) we_bad++;
    if (frame_done) fd_pos.push_back(wr_q.size());
    if (locked) locked_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_bits.push_back(v[i]);
  endtask

  // mode 0: byte i, 1: random, 2: random with bits 5 and 0 set (zero runs <= 6)
  task automatic add_frame(input logic [15:0] sw, input int mode);
    add_bits(32'(sw), 16);
    for (int i = 0; i < FL; i++) begin
      logic [7:0] b;
      case (mode)
        0:       b = 8'(i);
        1:       b = 8'($urandom);
        default: b = 8'($urandom) | 8'h21;
      endcase
      add_bits(32'(b), 8);
    end
  endtask

  // Reference: scan the decoded bit stream for the sync word, then cut bytes.
  task automatic model_run(input int nbits);
    logic [15:0] sr;
    logic [7:0]  by;
    bit cap;
    int nb, addr;
    sr = '0; by = '0; cap = 0; nb = 0; addr = 0;
    exp_wr.delete(); exp_fd.delete(); exp_frames = 0; exp_lock = 0;
    for (int i = 0; i < nbits; i++) begin
      if (!cap) begin
        sr = {sr[14:0], tx_bits[i]};
        if (sr == SYNC) begin cap = 1; nb = 0; addr = 0; exp_lock = 1; end
      end else begin
        by = {by[6:0], tx_bits[i]};
        nb++;
        if (nb == 8) begin
          exp_wr.push_back({addr[7:0], by});
          nb = 0; addr++;
          if (addr == FL) begin
            cap = 0; sr = '0; exp_frames++;
            exp_fd.push_back(exp_wr.size());
          end
        end
      end
    end
  endtask

  task automatic send(input int cpb, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (tx_bits[i]) phase_in = ~phase_in;
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic restart_rx(input logic ph);
    @(negedge clk);
    rx_en = 1'b0;
    phase_in = ph;
    repeat (3) @(negedge clk);
    wr_q.delete(); fd_pos.delete(); locked_seen = 1'b0;
    rx_en = 1'b1;
  endtask

  task automatic new_stream(input logic [15:0] sw, input int mode);
    tx_bits.delete();
    add_bits(32'hFFFFFFFF, PRE);
    add_frame(sw, mode);
    add_bits(32'hF, 4);
    model_run(tx_bits.size());
  endtask

  task automatic check_writes(input string tag);
    check({tag, " nwr"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_wr[i]));
    check({tag, " nfd"}, fd_pos.size(), exp_fd.size());
    for (int i = 0; i < exp_fd.size() && i < fd_pos.size(); i++)
      check($sformatf("%s fd%0d", tag, i), fd_pos[i], exp_fd[i]);
    check({tag, " fc"}, 32'(frame_count), exp_fc);
    check({tag, " we"}, we_bad, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " ram_en"}, 32'(ram_en), 0);
    check({tag, " ram_we"}, 32'(ram_we), 0);
    check({tag, " ram_addr"}, 32'(ram_addr), 0);
    check({tag, " ram_wr_data"}, 32'(ram_wr_data), 0);
    check({tag, " ram_rst"}, 32'(ram_rst), 0);
    check({tag, " locked"}, 32'(locked), 0);
    check({tag, " frame_done"}, 32'(frame_done), 0);
    check({tag, " frame_count"}, 32'(frame_count), 0);
  endtask

  initial begin
    int cut;
    nrst = 1'b0; rx_en = 1'b0; phase_in = 1'b0; we_bad = 0; exp_fc = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    nrst = 1'b1;

    // 1: counting payload at exact rate
    start_phase = 1'(($urandom) & 1);
    new_stream(SYNC, 0);
    restart_rx(start_phase);
    send(CPB, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t1");

    // 2: same stream, inverted carrier phase
    restart_rx(~start_phase);
    send(CPB, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t2");

    // 3: transmitter clock offset, sparse-transition payload
    new_stream(SYNC, 2);
    restart_rx(phase_in);
    send(CPB + 1, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t3 slow");
    new_stream(SYNC, 2);
    restart_rx(phase_in);
    send(CPB - 1, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t3 fast");

    // 4: corrupted sync word
    new_stream(SYNC ^ 16'h0020, 1);
    restart_rx(phase_in);
    send(CPB, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t4");
    check("t4 locked", 32'(locked_seen), 32'(exp_lock));

    // 5: abort after byte 40, then a full frame
    new_stream(SYNC, 1);
    cut = PRE + 16 + 41 * 8;
    model_run(cut);
    restart_rx(phase_in);
    send(CPB, cut + 2);
    rx_en = 1'b0;
    repeat (40) @(negedge clk);
    check_writes("t5 abort");
    new_stream(SYNC, 1);
    restart_rx(phase_in);
    send(CPB, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t5 full");

    // 6: reset mid-capture, then two back-to-back frames
    new_stream(SYNC, 1);
    cut = PRE + 16 + 10 * 8;
    model_run(cut);
    restart_rx(phase_in);
    send(CPB, cut);
    check("t6 locked", 32'(locked), 32'(exp_lock));
    nrst = 1'b0;
    @(negedge clk);
    check_zero_outputs("t6 reset");
    nrst = 1'b1;
    exp_fc = 0;
    wr_q.delete(); fd_pos.delete();
    tx_bits.delete();
    add_bits(32'hFFFFFFFF, PRE);
    add_frame(SYNC, 1);
    add_frame(SYNC, 1);
    add_bits(32'hF, 4);
    model_run(tx_bits.size());
    send(CPB, tx_bits.size());
    exp_fc += exp_frames;
    check_writes("t6 b2b");
    check("t6 frames", exp_frames, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
